uart_program_loader: RTL and testbench
======================================

Name: uart_program_loader

Overview:
- Front-end that fills instruction/data memory over a serial link before the single-cycle CPU runs.
- Receives 8N1 UART bytes, assembles little-endian 32-bit words, and presents them on UartData/UartAddress.
- Raises UartOver once the image is complete; the CPU consumes these three signals directly, so UartOver=0 holds memory port B under loader control.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit, minimum 4.
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word.
- MAX_WORDS, 16384, upper bound on the word count; larger headers are clamped.
- HOLD_CYCLES, 4, cycles the last word is held stable before UartOver rises, minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- rx  in  1  UART receive line, idle high, asynchronous to clk
- UartData  out  32  assembled word
- UartAddress  out  32  byte address of UartData
- WordValid  out  1  one-cycle pulse when UartData/UartAddress update
- UartOver  out  1  load complete, sticky until reset
- FrameError  out  1  sticky flag, any stop bit sampled low
- WordCount  out  32  words committed so far

Behaviour:
- Reset values (reset=0, async): UartData=0, UartAddress=BASE_ADDR, WordValid=0, UartOver=0, FrameError=0, WordCount=0. All FSMs go to idle/S_LEN.
- rx passes through a 2-flop synchronizer before use; the synchronized value resets to 1.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized 1->0 edge.
  - START: wait CLKS_PER_BIT/2 cycles (integer divide), then sample the line.
    - Sample = 1: glitch; return to IDLE and discard.
    - Sample = 0: go to DATA.
  - DATA: sample 8 bits, LSB first, spaced CLKS_PER_BIT cycles apart.
  - STOP: sample one bit CLKS_PER_BIT later.
    - Stop = 1: an internal byte_valid pulses on the next cycle.
    - Stop = 0: the byte is discarded, FrameError <= 1, and the FSM waits in IDLE until the line reads 1 before accepting a new falling edge.
- Loader FSM states: S_LEN, S_DATA, S_FLUSH, S_DONE. A byte counter b (0..3) selects the lane: byte b goes to bits [8b+7:8b].
  - S_LEN: collect 4 bytes into N (little-endian). On the 4th byte, N_eff = min(N, MAX_WORDS).
    - N_eff = 0: go to S_FLUSH.
    - Otherwise: go to S_DATA with idx=0.
  - S_DATA: on the 4th byte of a word, the next cycle does all of the following:
    - UartData <= word.
    - UartAddress <= BASE_ADDR + (idx<<2), 32-bit wrap.
    - WordValid pulses for 1 cycle.
    - idx++ and WordCount++.
    - If idx+1 == N_eff, go to S_FLUSH.
    - Latency: WordValid asserts 2 cycles after the final stop-bit sample.
  - S_FLUSH: count HOLD_CYCLES cycles with UartData/UartAddress held, then UartOver <= 1 and go to S_DONE.
  - S_DONE: all received bytes are ignored. Outputs are frozen. UartOver stays 1.
- UartData and UartAddress change only on WordValid cycles, so repeated memory writes while UartOver=0 are idempotent.
- A frame error never advances b, idx or state; a lost byte shifts later bytes and is not resynchronized. FrameError tells the host to reset and resend.
- Reset mid-load: everything returns to reset values immediately. A partial word is never written. UartOver=0 stalls the CPU until a full reload.
- A byte arriving during S_FLUSH is ignored.

Test Plan (CLKS_PER_BIT=8, BASE_ADDR=0, HOLD_CYCLES=4):
- Send header 02 00 00 00, then 13 05 10 00, then EF BE AD DE. Required: WordValid pulses with (UartAddress=0, UartData=0x00100513), then (4, 0xDEADBEEF). UartOver rises exactly 4 cycles after the second pulse. WordCount=2.
- Header 00 00 00 00 -> no WordValid. UartOver=1 four cycles after the 4th byte commits. Subsequent bytes change nothing.
- Stop bit driven 0 on the 2nd data byte -> FrameError=1. That byte is discarded and no WordValid occurs for the stalled word. Error persists until reset=0.
- 2-cycle low glitch on an idle rx -> no byte accepted, no state change.
- Assert reset=0 after 3 of 4 bytes of word 1 -> all outputs at reset values at once. A full resend loads correctly from address 0.
- Header with N=0x0001_0000 and MAX_WORDS=4 -> exactly 4 WordValid pulses at addresses 0, 4, 8, 12, then UartOver=1.

Source files
------------

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - serial program loader filling CPU memory with little-endian words
//
// Receives 8N1 bytes on rx. The first four bytes are the word count N,
// clamped to MAX_WORDS. The following bytes are packed into 32-bit words.
// Each word is presented for memory port B at BASE_ADDR + 4*idx.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   rx           UART receive line, idle high, asynchronous to clk
//   UartData     last committed word
//   UartAddress  byte address of UartData
//   WordValid    one-cycle pulse when UartData/UartAddress update
//   UartOver     load complete, sticky until reset
//   FrameError   sticky, set when any stop bit is sampled low
//   WordCount    number of words committed so far
module uart_program_loader #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned MAX_WORDS    = 16384,
  parameter int unsigned HOLD_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [31:0] UartData,
  output logic [31:0] UartAddress,
  output logic        WordValid,
  output logic        UartOver,
  output logic        FrameError,
  output logic [31:0] WordCount
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD_CYCLES - 1);
  localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] S_LEN   = 2'd0;
  localparam logic [1:0] S_DATA  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // rx synchronizer; rx_prev_q is one more stage, used only for edge detect
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------- byte receiver ----------------
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;

  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        // A true 1->0 edge is required, so after a bad stop bit the line
        // must return high before the next frame is accepted.
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d      = '0;
          bit_d      = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) byte_valid_d = 1'b1;
          else           frame_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // ---------------- word loader ----------------
  logic [1:0]    ld_state_q, ld_state_d;
  logic [1:0]    b_q, b_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   n_eff_q, n_eff_d;
  logic [31:0]   idx_q, idx_d;
  logic [HW-1:0] flush_q, flush_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   addr_q, addr_d;
  logic          wv_q, wv_d;
  logic          over_q, over_d;
  logic [31:0]   wc_q, wc_d;
  logic [31:0]   assembled;

  // Current accumulator with the incoming byte dropped into lane b.
  always_comb begin
    assembled = acc_q;
    assembled[8*b_q +: 8] = shift_q;
  end

  always_comb begin
    ld_state_d = ld_state_q;
    b_d        = b_q;
    acc_d      = acc_q;
    n_eff_d    = n_eff_q;
    idx_d      = idx_q;
    flush_d    = flush_q;
    data_d     = data_q;
    addr_d     = addr_q;
    wv_d       = 1'b0;
    over_d     = over_q;
    wc_d       = wc_q;
    unique case (ld_state_q)
      S_LEN: begin
        if (byte_valid_q) begin
          acc_d = assembled;
          b_d   = b_q + 2'd1;
          if (b_q == 2'd3) begin
            n_eff_d    = (assembled > MAX_N) ? MAX_N : assembled;
            idx_d      = '0;
            flush_d    = '0;
            ld_state_d = (n_eff_d == 32'd0) ? S_FLUSH : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (byte_valid_q) begin
          acc_d = assembled;
          b_d   = b_q + 2'd1;
          if (b_q == 2'd3) begin
            data_d  = assembled;
            addr_d  = BASE_ADDR + (idx_q << 2);
            wv_d    = 1'b1;
            idx_d   = idx_q + 32'd1;
            wc_d    = wc_q + 32'd1;
            flush_d = '0;
            if (idx_q + 32'd1 == n_eff_q) ld_state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // Outputs stay put while the final write settles; bytes are ignored.
        if (flush_q == HOLD_M1) begin
          over_d     = 1'b1;
          ld_state_d = S_DONE;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_state_q <= S_LEN;
      b_q        <= '0;
      acc_q      <= '0;
      n_eff_q    <= '0;
      idx_q      <= '0;
      flush_q    <= '0;
      data_q     <= '0;
      addr_q     <= BASE_ADDR;
      wv_q       <= 1'b0;
      over_q     <= 1'b0;
      wc_q       <= '0;
    end else begin
      ld_state_q <= ld_state_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      n_eff_q    <= n_eff_d;
      idx_q      <= idx_d;
      flush_q    <= flush_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      wv_q       <= wv_d;
      over_q     <= over_d;
      wc_q       <= wc_d;
    end
  end

  assign UartData    = data_q;
  assign UartAddress = addr_q;
  assign WordValid   = wv_q;
  assign UartOver    = over_q;
  assign FrameError  = frame_err_q;
  assign WordCount   = wc_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - randomized self-checking bench for uart_program_loader
module tb_uart_program_loader;

  localparam int CPB  = 8;
  localparam int MAXW = 4;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] UartData, UartAddress, WordCount;
  logic        WordValid, UartOver, FrameError;

  always #5 clk = ~clk;

  uart_program_loader #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR   (32'h0000_0000),
    .MAX_WORDS   (MAXW),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .UartData   (UartData),
    .UartAddress(UartAddress),
    .WordValid  (WordValid),
    .UartOver   (UartOver),
    .FrameError (FrameError),
    .WordCount  (WordCount)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] tx_words[$];
  int last_wv_cyc = 0;
  int over_cyc = 0;
  bit over_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the write port the way the memory would.
  always @(negedge clk) begin
    if (reset) begin
      if (WordValid) begin
        got_addr.push_back(UartAddress);
        got_data.push_back(UartData);
        last_wv_cyc = cyc;
      end
      if (UartOver && !over_seen) begin
        over_seen = 1'b1;
        over_cyc  = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    got_addr.delete();
    got_data.delete();
    over_seen = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    clear_mon();
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"}, UartData, 32'h0);
    check({tag, "_addr"}, UartAddress, 32'h0);
    check({tag, "_wv"}, {31'b0, WordValid}, 32'h0);
    check({tag, "_over"}, {31'b0, UartOver}, 32'h0);
    check({tag, "_ferr"}, {31'b0, FrameError}, 32'h0);
    check({tag, "_wcnt"}, WordCount, 32'h0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  // Reference: the first min(N, MAX_WORDS) words land at 4*i, nothing else.
  task automatic run_load(input logic [31:0] hdr, input int nsend, input string tag);
    int n_eff;
    n_eff = (hdr > 32'(MAXW)) ? MAXW : int'(hdr);
    send_word(hdr);
    for (int i = 0; i < nsend; i++) send_word(tx_words[i]);
    repeat (20) @(negedge clk);
    check({tag, "_wv_count"}, 32'(got_data.size()), 32'(n_eff));
    for (int i = 0; i < n_eff; i++) begin
      if (i < got_data.size()) begin
        check($sformatf("%s_addr%0d", tag, i), got_addr[i], 32'(4 * i));
        check($sformatf("%s_data%0d", tag, i), got_data[i], tx_words[i]);
      end
    end
    check({tag, "_over"}, {31'b0, UartOver}, 32'h1);
    if (n_eff > 0 && over_seen)
      check({tag, "_over_delay"}, 32'(over_cyc - last_wv_cyc), 32'(HOLD));
    check({tag, "_wcnt"}, WordCount, 32'(n_eff));
    check({tag, "_final_data"}, UartData, (n_eff > 0) ? tx_words[n_eff-1] : 32'h0);
    check({tag, "_ferr"}, {31'b0, FrameError}, 32'h0);
  endtask

  initial begin
    int n;
    int nsend;
    logic [31:0] hdr;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("por");

    // Two-word program, then an extra word after completion that must be ignored.
    do_reset();
    tx_words = '{32'h0010_0513, 32'hDEAD_BEEF, 32'h1234_5678};
    run_load(32'd2, 3, "two_words");

    // Empty image.
    do_reset();
    tx_words = '{$urandom, $urandom, $urandom};
    run_load(32'd0, 3, "empty");

    // Short low glitch on an idle line must not start a byte.
    do_reset();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    check("glitch_wcnt", WordCount, 32'h0);
    check("glitch_ferr", {31'b0, FrameError}, 32'h0);
    tx_words = '{$urandom};
    run_load(32'd1, 1, "glitch");

    // Bad stop bit on the second data byte stalls the word.
    do_reset();
    send_word(32'd1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    repeat (20) @(negedge clk);
    check("ferr_flag", {31'b0, FrameError}, 32'h1);
    check("ferr_wv_count", 32'(got_data.size()), 32'h0);
    check("ferr_over", {31'b0, UartOver}, 32'h0);
    check("ferr_wcnt", WordCount, 32'h0);
    repeat (200) @(negedge clk);
    check("ferr_sticky", {31'b0, FrameError}, 32'h1);
    do_reset();
    check("ferr_cleared", {31'b0, FrameError}, 32'h0);

    // Reset in the middle of the first word, then a full reload.
    do_reset();
    tx_words = '{$urandom, $urandom};
    send_word(32'd2);
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (2) @(negedge clk);
    clear_mon();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_load(32'd2, 2, "reload");

    // Oversized header is clamped to MAX_WORDS.
    do_reset();
    tx_words = '{$urandom, $urandom, $urandom, $urandom, $urandom};
    run_load(32'h0001_0000, 5, "clamp");

    // Randomized images.
    for (int it = 0; it < 5; it++) begin
      do_reset();
      n = $urandom_range(0, 7);
      hdr = (it == 4) ? $urandom : 32'(n);
      nsend = ((hdr > 32'(MAXW)) ? MAXW : int'(hdr)) + $urandom_range(0, 1);
      tx_words.delete();
      for (int i = 0; i < nsend; i++) tx_words.push_back($urandom);
      run_load(hdr, nsend, $sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
